// File: rtl/serial_sub_if.sv
// Operand/result bundle for serial_sub_ctrl. Z is present only when SERIAL_SUB_ZERO_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] D;
    logic             B;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_ZERO_EN
    logic             Z;

    modport master (output start, X, Y, input D, B, busy, done, Z);
    modport slave  (input start, X, Y, output D, B, busy, done, Z);
`else
    modport master (output start, X, Y, input D, B, busy, done);
    modport slave  (input start, X, Y, output D, B, busy, done);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one 1-bit full-subtractor cell stepped LSB first over WIDTH cycles.
// Optional zero flag Z is built in when SERIAL_SUB_ZERO_EN is defined.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_shift;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             br_nxt;
    logic             d_bit;
    logic             busy_reg;
    logic             done_reg;
    logic             accept;
    logic             last;
    logic [1:0]       hs1;
    logic [1:0]       hs2;

    // Half subtractor: {difference, borrow}
    function automatic logic [1:0] half_sub(input logic a, input logic b);
        return {a ^ b, ~a & b};
    endfunction

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Full subtractor cell built from two half subtractors and a borrow OR
    always_comb begin
        hs1          = half_sub(xs[0], ys[0]);
        hs2          = half_sub(hs1[1], br);
        d_bit        = hs2[1];
        br_nxt       = hs1[0] | hs2[0];
        res_shift    = res >> 1;
        res_shift[WIDTH-1] = d_bit;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_reg <= (state_nxt == RUN);
            done_reg <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            xs  <= bus.X;
            ys  <= bus.Y;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            xs  <= xs >> 1;
            ys  <= ys >> 1;
            res <= res_shift;
            br  <= br_nxt;
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef SERIAL_SUB_ZERO_EN
    logic zero;

    // Captured from the final shifted result on the step that enters DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
        end else if (state == RUN && last) begin
            zero <= (res_shift == '0);
        end
    end

    assign bus.Z = zero;
`endif

    assign bus.D    = res;
    assign bus.B    = br;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl at WIDTH 4, 8 and 1 with a transaction-level model and literal pins.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(4)) bus4 ();
    serial_sub_if #(.WIDTH(8)) bus8 ();
    serial_sub_if #(.WIDTH(1)) bus1 ();

    serial_sub_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic       st_drv [3];
    logic [3:0] x4, y4;
    logic [7:0] x8, y8;
    logic [0:0] x1, y1;

    assign bus4.start = st_drv[0];
    assign bus8.start = st_drv[1];
    assign bus1.start = st_drv[2];
    assign bus4.X = x4;  assign bus4.Y = y4;
    assign bus8.X = x8;  assign bus8.Y = y8;
    assign bus1.X = x1;  assign bus1.Y = y1;

    logic [31:0] xv [3];
    logic [31:0] yv [3];
    logic [31:0] dv [3];
    logic        bv [3];
    logic        busyv [3];
    logic        donev [3];
    assign xv[0] = 32'(x4);  assign yv[0] = 32'(y4);
    assign xv[1] = 32'(x8);  assign yv[1] = 32'(y8);
    assign xv[2] = 32'(x1);  assign yv[2] = 32'(y1);
    assign dv[0] = 32'(bus4.D);  assign dv[1] = 32'(bus8.D);  assign dv[2] = 32'(bus1.D);
    assign bv[0] = bus4.B;       assign bv[1] = bus8.B;       assign bv[2] = bus1.B;
    assign busyv[0] = bus4.busy; assign busyv[1] = bus8.busy; assign busyv[2] = bus1.busy;
    assign donev[0] = bus4.done; assign donev[1] = bus8.done; assign donev[2] = bus1.done;
`ifdef SERIAL_SUB_ZERO_EN
    logic zv [3];
    assign zv[0] = bus4.Z;  assign zv[1] = bus8.Z;  assign zv[2] = bus1.Z;
`endif

    function automatic int wid(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 1;
    endfunction

    function automatic logic [31:0] mask(input int k);
        return (32'd1 << wid(k)) - 32'd1;
    endfunction

    // Transaction model: an accepted operation occupies W cycles, then reports (X-Y) mod 2^W and X<Y.
    logic [31:0] m_d [3];
    logic        m_b [3];
    logic        m_z [3];
    logic        m_done [3];
    int          m_left [3];
    logic [31:0] p_d [3];
    logic        p_b [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_d[k] <= '0; m_b[k] <= 1'b0; m_z[k] <= 1'b0;
                m_left[k] <= 0; m_done[k] <= 1'b0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_left[k] > 0) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_done[k] <= 1'b1;
                        m_d[k]    <= p_d[k];
                        m_b[k]    <= p_b[k];
                        m_z[k]    <= (p_d[k] == 32'd0);
                    end
                end else if (st_drv[k]) begin
                    p_d[k]    <= (xv[k] - yv[k]) & mask(k);
                    p_b[k]    <= (xv[k] < yv[k]);
                    m_left[k] <= wid(k);
                end
            end
        end
    end

    logic [31:0] lit_d [3][8];
    logic        lit_b [3][8];
    int          lit_n [3];
    int          rd_idx [3];
    bit          fin = 1'b0;
    bit          fin_seen = 1'b0;
    int          chk = 0;
    int          err = 0;

    task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s w%0d t=%0t got %0d want %0d", nm, wid(k), $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            cmp("busy", k, 32'(busyv[k]), 32'(m_left[k] > 0));
            cmp("done", k, 32'(donev[k]), 32'(m_done[k]));
            if (m_left[k] == 0) begin
                cmp("D", k, dv[k], m_d[k]);
                cmp("B", k, 32'(bv[k]), 32'(m_b[k]));
            end
`ifdef SERIAL_SUB_ZERO_EN
            cmp("Z", k, 32'(zv[k]), 32'(m_z[k]));
`endif
            if (m_done[k]) begin
                if (rd_idx[k] < lit_n[k]) begin
                    cmp("model_D", k, m_d[k], lit_d[k][rd_idx[k]]);
                    cmp("model_B", k, 32'(m_b[k]), 32'(lit_b[k][rd_idx[k]]));
                    rd_idx[k]++;
                end else begin
                    chk++;
                    err++;
                    $display("FAIL extra_done w%0d t=%0t got %0d results want %0d", wid(k), $time,
                             rd_idx[k] + 1, lit_n[k]);
                end
            end
        end
        if (fin && !fin_seen) begin
            fin_seen = 1'b1;
            for (int k = 0; k < 3; k++) cmp("result_count", k, 32'(rd_idx[k]), 32'(lit_n[k]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input int k, input int d, input bit b);
        lit_d[k][lit_n[k]] = 32'(d);
        lit_b[k][lit_n[k]] = b;
        lit_n[k]++;
    endtask

    task automatic set_xy(input int k, input int x, input int y);
        case (k)
            0: begin x4 = 4'(x); y4 = 4'(y); end
            1: begin x8 = 8'(x); y8 = 8'(y); end
            default: begin x1 = 1'(x); y1 = 1'(y); end
        endcase
    endtask

    // One-cycle start pulse; returns at the negedge of the first RUN cycle
    task automatic put(input int k, input int x, input int y, input bit has_lit, input int d, input bit b);
        set_xy(k, x, y);
        st_drv[k] = 1'b1;
        if (has_lit) lit(k, d, b);
        @(negedge clk);
        st_drv[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st_drv[k] = 1'b0; lit_n[k] = 0; rd_idx[k] = 0;
        end
        x4 = '0; y4 = '0; x8 = '0; y8 = '0; x1 = '0; y1 = '0;
        idle(3);
        rst = 1'b0;
        idle(2);

        put(0, 5, 3, 1, 2, 0);    idle(9);
        put(0, 3, 5, 1, 14, 1);   idle(6);
        put(0, 0, 1, 1, 15, 1);   idle(6);
        put(0, 15, 15, 1, 0, 0);  idle(6);

        // start pulse and operand change while running must not disturb 9-4
        put(0, 9, 4, 1, 5, 0);
        set_xy(0, 1, 7);
        st_drv[0] = 1'b1;
        @(negedge clk);
        st_drv[0] = 1'b0;
        idle(6);

        // reset lands on the second RUN cycle; that operation is discarded
        put(0, 6, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        put(0, 7, 2, 1, 5, 0);    idle(6);

        // start held high; second operands presented in the DONE cycle
        set_xy(1, 200, 55);
        st_drv[1] = 1'b1;
        lit(1, 145, 0);
        idle(9);
        set_xy(1, 10, 20);
        lit(1, 246, 1);
        @(negedge clk);
        st_drv[1] = 1'b0;
        idle(10);
        put(1, 0, 255, 1, 1, 1);  idle(10);

        put(2, 0, 1, 1, 1, 1);    idle(3);
        put(2, 1, 0, 1, 1, 0);    idle(3);
        put(2, 1, 1, 1, 0, 0);    idle(3);

        fin = 1'b1;
        idle(3);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
